echo_repeat: RTL and testbench
==============================

# echo_repeat

Parametrised successor to the single-entry echo: accepts `say` requests carrying a value and a repeat count, buffers up to DEPTH of them in a circular FIFO, and replays each value on the `heard` indication `rep+1` times, tagging each emission with a wrapping sequence number. Sits between a software request port and its indication port, as the echo test block for deeper, burstier traffic. All handshakes use the codebase method protocol: a method fires in a cycle when its `__ENA` and `__RDY` are both high.

## Interface
Parameters:
- WIDTH, 32, payload width of `v`
- DEPTH, 4, FIFO entries; power of two, ≥2
- REPW, 4, width of repeat count
- SEQW, 8, width of sequence tag

Ports:
- CLK  in  1  clock; all state on rising edge
- nRST  in  1  asynchronous, active-low reset
- sout$say__ENA  in  1  enqueue request; legal only while `sout$say__RDY`=1
- sout$say$v  in  WIDTH  payload
- sout$say$rep  in  REPW  extra repetitions (0 = emit once)
- sout$say__RDY  out  1  space available
- ind$heard__ENA  out  1  indication valid this cycle
- ind$heard$v  out  WIDTH  payload of head entry
- ind$heard$seq  out  SEQW  emission sequence tag
- ind$heard__RDY  in  1  downstream can take indication
- occupancy  out  clog2(DEPTH)+1  entries currently stored

## Operation
- Storage: DEPTH×(WIDTH+REPW) array, write pointer `wp`, read pointer `rp` (clog2(DEPTH) bits, natural wrap), count `cnt` (0..DEPTH).
- Enqueue fires: `sout$say__ENA & sout$say__RDY`; writes {v,rep} at `wp`, `wp++`.
- `sout$say__RDY = (cnt != DEPTH)`; 0 while nRST low.
- `ind$heard__ENA = (cnt != 0) & ind$heard__RDY` (combinational on RDY, codebase style); `ind$heard$v` = head payload whenever `cnt != 0`, else 0.
- Repeat counter `rc` (REPW bits), counts emissions of the current head.
- On heard fire: `seq++` (mod 2^SEQW). If `rc == head.rep`, dequeue (`rp++`, `rc`←0); else `rc++`.
- `cnt` next = cnt + enq_fire − deq_fire; simultaneous enqueue and dequeue leaves `cnt` unchanged, both pointers advance.
- `occupancy = cnt`.
- An `__ENA` without `__RDY` is ignored (no state change). Verification flags it as a protocol error.

## Timing
- Reset (async assert, sync release, no wait states): `wp`=`rp`=`cnt`=`rc`=`seq`=0, all array contents don't-care. Outputs: `ind$heard__ENA`=0, `ind$heard$v`=0, `ind$heard$seq`=0, `occupancy`=0, `sout$say__RDY`=0 during reset and 1 the first cycle after release.
- Latency: entry enqueued in cycle t is first presented as head no earlier than t+1. There is no same-cycle bypass through an empty FIFO.
- Full (cnt=DEPTH): `sout$say__RDY`=0 even if a dequeue fires that cycle. It rises the cycle after that dequeue.
- Empty: `ind$heard__ENA`=0 regardless of `ind$heard__RDY`.
- rep = 2^REPW−1 yields 2^REPW emissions of that entry.
- Pointer wrap at DEPTH and `seq` wrap at 2^SEQW are silent.
- Back-to-back throughput: one emission per cycle while `ind$heard__RDY`=1 and not empty. One enqueue per cycle while not full.
- Reset mid-replay discards the partially emitted entry and all queued entries.

## Structure
- Package `echo_pkg`: entry struct typedef {v, rep}, parameter defaults, and a `clog2` constant function.
- Sub-module `fifo_n_base #(type T, DEPTH)`: circular buffer with `in$enq`/`out$deq`/`out$first` methods and `count` output. `echo_repeat` adds the repeat counter, sequence counter and handshake glue, about 150 lines total.

## Test plan
- Reset then single say(v=0x12345678, rep=0) with heard RDY=1 -> exactly one heard, v=0x12345678, seq=0, one cycle after enqueue; occupancy back to 0.
- say(v=0xA, rep=2) -> three consecutive heard fires v=0xA, seq=0,1,2; entry dequeued on the third.
- Hold heard RDY=0, issue 4 says (DEPTH=4) -> say RDY drops after 4th, occupancy=4. A 5th ENA is flagged and not stored. Release RDY -> 4 emissions in order, say RDY returns the cycle after the first dequeue.
- Continuous say and heard, rep=0, 20 items -> simultaneous enq/deq keeps occupancy steady, pointers wrap, order preserved, seq increments with no gaps.
- 300 emissions (SEQW=8) -> seq wraps 255→0.
- Assert nRST mid-replay of rep=3 entry after 2 emissions -> all outputs reset asynchronously. After release: occupancy=0, next say emits with seq=0.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared types and helpers for the echo_repeat block and its FIFO.
package echo_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 4;
    localparam int REPW_DEF  = 4;
    localparam int SEQW_DEF  = 8;

    // One queued say request at the default widths; the top rebuilds the
    // same shape locally when its parameters differ from the defaults.
    typedef struct packed {
        logic [WIDTH_DEF-1:0] v;
        logic [REPW_DEF-1:0]  rep;
    } echo_entry_t;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int n);
        int r;
        int x;
        r = 0;
        x = n - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_n_base.sv
// Circular buffer of DEPTH entries of type T with enq/deq/first methods.
// Storage is not reset; only the pointers and the count are.
module fifo_n_base
    import echo_pkg::*;
#(
    parameter type T         = echo_entry_t,
    parameter int  DEPTH     = DEPTH_DEF,
    localparam int AW        = clog2(DEPTH),
    localparam int CW        = clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          in_enq__ENA,
    input  T              in_enq_v,
    output logic          in_enq__RDY,
    input  logic          out_deq__ENA,
    output logic          out_deq__RDY,
    output T              out_first,
    output logic          out_first__RDY,
    output logic [CW-1:0] count
);

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    T              mem [DEPTH];
    logic          enq_fire;
    logic          deq_fire;

    // Full blocks enqueue even when a dequeue fires in the same cycle, so the
    // ready path never depends on the consumer.
    assign in_enq__RDY    = (cnt != CW'(DEPTH));
    assign out_deq__RDY   = (cnt != '0);
    assign out_first__RDY = (cnt != '0);
    assign out_first      = mem[rp];
    assign count          = cnt;

    assign enq_fire = in_enq__ENA  & in_enq__RDY;
    assign deq_fire = out_deq__ENA & out_deq__RDY;

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (enq_fire) begin
                wp <= wp + AW'(1);
            end
            if (deq_fire) begin
                rp <= rp + AW'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (enq_fire) begin
            mem[wp] <= in_enq_v;
        end
    end

endmodule

// File: rtl/echo_repeat.sv
// Buffered echo: queues say requests and replays each value rep+1 times on
// the heard indication, stamping every emission with a wrapping sequence tag.
module echo_repeat
    import echo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int REPW  = REPW_DEF,
    parameter int SEQW  = SEQW_DEF,
    localparam int CW   = clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             sout_say__ENA,
    input  logic [WIDTH-1:0] sout_say_v,
    input  logic [REPW-1:0]  sout_say_rep,
    output logic             sout_say__RDY,
    output logic             ind_heard__ENA,
    output logic [WIDTH-1:0] ind_heard_v,
    output logic [SEQW-1:0]  ind_heard_seq,
    input  logic             ind_heard__RDY,
    output logic [CW-1:0]    occupancy
);

    typedef struct packed {
        logic [WIDTH-1:0] v;
        logic [REPW-1:0]  rep;
    } entry_t;

    entry_t          say_entry;
    entry_t          head;
    logic            fifo_enq_rdy;
    logic            fifo_deq_rdy;
    logic            head_valid;
    logic [CW-1:0]   fifo_count;
    logic            say_fire;
    logic            heard_fire;
    logic            last_rep;
    logic            deq_fire;
    logic [REPW-1:0] rc;
    logic [SEQW-1:0] seq;

    assign say_entry.v   = sout_say_v;
    assign say_entry.rep = sout_say_rep;

    // Ready is forced low while reset is held so nothing can be accepted
    // before the pointers are released.
    assign sout_say__RDY = nRST & fifo_enq_rdy;
    assign say_fire      = sout_say__ENA & sout_say__RDY;

    assign ind_heard__ENA = fifo_deq_rdy & ind_heard__RDY;
    assign ind_heard_v    = head_valid ? head.v : '0;
    assign ind_heard_seq  = seq;
    assign heard_fire     = ind_heard__ENA;

    // The head leaves the queue on its final repetition only.
    assign last_rep = (rc == head.rep);
    assign deq_fire = heard_fire & last_rep;

    assign occupancy = fifo_count;

    fifo_n_base #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK            (CLK),
        .nRST           (nRST),
        .in_enq__ENA    (say_fire),
        .in_enq_v       (say_entry),
        .in_enq__RDY    (fifo_enq_rdy),
        .out_deq__ENA   (deq_fire),
        .out_deq__RDY   (fifo_deq_rdy),
        .out_first      (head),
        .out_first__RDY (head_valid),
        .count          (fifo_count)
    );

    // Repeat and sequence counters advance on every heard emission.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rc  <= '0;
            seq <= '0;
        end else if (heard_fire) begin
            seq <= seq + SEQW'(1);
            if (last_rep) begin
                rc <= '0;
            end else begin
                rc <= rc + REPW'(1);
            end
        end
    end

endmodule

// File: tb/tb_echo_repeat.sv
module tb_echo_repeat;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        say_ena = 1'b0;
    logic [31:0] say_v = '0;
    logic [3:0]  say_rep = '0;
    logic        say_rdy;
    logic        heard_ena;
    logic [31:0] heard_v;
    logic [7:0]  heard_seq;
    logic        heard_rdy = 1'b0;
    logic [2:0]  occ;

    int checks = 0;
    int errors = 0;

    echo_repeat dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .sout_say__ENA  (say_ena),
        .sout_say_v     (say_v),
        .sout_say_rep   (say_rep),
        .sout_say__RDY  (say_rdy),
        .ind_heard__ENA (heard_ena),
        .ind_heard_v    (heard_v),
        .ind_heard_seq  (heard_seq),
        .ind_heard__RDY (heard_rdy),
        .occupancy      (occ)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        say_ena;
        logic [31:0] v;
        logic [3:0]  rep;
        logic        rdy;
        logic        e_say_rdy;
        logic        e_ena;
        logic [31:0] e_v;
        logic [7:0]  e_seq;
        logic [2:0]  e_occ;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic se, input logic [31:0] v, input logic [3:0] rep,
                                input logic rdy, input logic esr, input logic ee,
                                input logic [31:0] ev, input logic [7:0] es, input logic [2:0] eo);
        vec_t r;
        r.say_ena = se; r.v = v; r.rep = rep; r.rdy = rdy;
        r.e_say_rdy = esr; r.e_ena = ee; r.e_v = ev; r.e_seq = es; r.e_occ = eo;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        say_ena = 1'b0; say_v = '0; say_rep = '0; heard_rdy = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        int sent, got, n, nq;

        // Cycle-by-cycle vectors, continuing from reset with seq carried over.
        vecs[0]  = mk(1, 32'h12345678, 0, 1,  1, 0, 32'h0,        8'd0,  3'd0);
        vecs[1]  = mk(0, 32'h0,        0, 1,  1, 1, 32'h12345678, 8'd0,  3'd1);
        vecs[2]  = mk(1, 32'hA,        2, 1,  1, 0, 32'h0,        8'd1,  3'd0);
        vecs[3]  = mk(0, 32'h0,        0, 1,  1, 1, 32'hA,        8'd1,  3'd1);
        vecs[4]  = mk(0, 32'h0,        0, 1,  1, 1, 32'hA,        8'd2,  3'd1);
        vecs[5]  = mk(0, 32'h0,        0, 1,  1, 1, 32'hA,        8'd3,  3'd1);
        vecs[6]  = mk(0, 32'h0,        0, 0,  1, 0, 32'h0,        8'd4,  3'd0);
        vecs[7]  = mk(1, 32'h100,      0, 0,  1, 0, 32'h0,        8'd4,  3'd0);
        vecs[8]  = mk(1, 32'h101,      0, 0,  1, 0, 32'h100,      8'd4,  3'd1);
        vecs[9]  = mk(1, 32'h102,      0, 0,  1, 0, 32'h100,      8'd4,  3'd2);
        vecs[10] = mk(1, 32'h103,      0, 0,  1, 0, 32'h100,      8'd4,  3'd3);
        vecs[11] = mk(1, 32'hDEAD,     0, 0,  0, 0, 32'h100,      8'd4,  3'd4);
        vecs[12] = mk(0, 32'h0,        0, 1,  0, 1, 32'h100,      8'd4,  3'd4);
        vecs[13] = mk(0, 32'h0,        0, 1,  1, 1, 32'h101,      8'd5,  3'd3);
        vecs[14] = mk(0, 32'h0,        0, 1,  1, 1, 32'h102,      8'd6,  3'd2);
        vecs[15] = mk(0, 32'h0,        0, 1,  1, 1, 32'h103,      8'd7,  3'd1);
        vecs[16] = mk(0, 32'h0,        0, 1,  1, 0, 32'h0,        8'd8,  3'd0);
        vecs[17] = mk(1, 32'h55,       0, 1,  1, 0, 32'h0,        8'd8,  3'd0);
        vecs[18] = mk(1, 32'h66,       1, 1,  1, 1, 32'h55,       8'd8,  3'd1);
        vecs[19] = mk(0, 32'h0,        0, 1,  1, 1, 32'h66,       8'd9,  3'd1);
        vecs[20] = mk(0, 32'h0,        0, 1,  1, 1, 32'h66,       8'd10, 3'd1);
        vecs[21] = mk(0, 32'h0,        0, 1,  1, 0, 32'h0,        8'd11, 3'd0);

        // Reset state while nRST is held low.
        heard_rdy = 1'b1;
        #2;
        chk("rst say_rdy",   64'(say_rdy),   64'd0);
        chk("rst heard_ena", 64'(heard_ena), 64'd0);
        chk("rst heard_v",   64'(heard_v),   64'd0);
        chk("rst heard_seq", 64'(heard_seq), 64'd0);
        chk("rst occupancy", 64'(occ),       64'd0);
        heard_rdy = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk("post-rst say_rdy", 64'(say_rdy), 64'd1);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge CLK);
            say_ena = vecs[i].say_ena; say_v = vecs[i].v; say_rep = vecs[i].rep;
            heard_rdy = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d say_rdy", i),   64'(say_rdy),   64'(vecs[i].e_say_rdy));
            chk($sformatf("vec%0d heard_ena", i), 64'(heard_ena), 64'(vecs[i].e_ena));
            chk($sformatf("vec%0d heard_v", i),   64'(heard_v),   64'(vecs[i].e_v));
            chk($sformatf("vec%0d heard_seq", i), 64'(heard_seq), 64'(vecs[i].e_seq));
            chk($sformatf("vec%0d occupancy", i), 64'(occ),       64'(vecs[i].e_occ));
        end

        // Streaming: 20 items, rep=0, continuous say and heard.
        do_reset();
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            @(negedge CLK);
            say_ena = (sent < 20); say_v = 32'(sent + 32'h1000); say_rep = 0; heard_rdy = 1'b1;
            #1;
            chk("stream occupancy", 64'(occ), 64'(sent - got));
            if (heard_ena) begin
                chk("stream v",   64'(heard_v),   64'(got + 32'h1000));
                chk("stream seq", 64'(heard_seq), 64'(got & 255));
                got++;
            end
            if (say_ena && say_rdy) sent++;
        end
        chk("stream emissions", 64'(got), 64'd20);

        // Max repeat count and sequence wrap: 19 entries of rep=15 -> 304 emissions.
        do_reset();
        n = 0; nq = 0;
        for (int cyc = 0; cyc < 2000 && n < 304; cyc++) begin
            @(negedge CLK);
            say_ena = say_rdy && (nq < 19); say_v = 32'(nq); say_rep = 4'hF; heard_rdy = 1'b1;
            #1;
            if (heard_ena) begin
                chk("wrap v",   64'(heard_v),   64'(n >> 4));
                chk("wrap seq", 64'(heard_seq), 64'(n & 255));
                n++;
            end
            if (say_ena) nq++;
        end
        chk("wrap emissions", 64'(n), 64'd304);
        @(negedge CLK);
        say_ena = 1'b0;
        #1;
        chk("wrap drained occupancy", 64'(occ), 64'd0);
        chk("wrap drained heard_ena", 64'(heard_ena), 64'd0);

        // Reset in the middle of a rep=3 replay after two emissions.
        do_reset();
        @(negedge CLK);
        say_ena = 1'b1; say_v = 32'hBEEF; say_rep = 4'd3; heard_rdy = 1'b1;
        @(negedge CLK);
        say_ena = 1'b0;
        #1;
        chk("mid first emission seq", 64'(heard_seq), 64'd0);
        @(negedge CLK);
        #1;
        chk("mid second emission ena", 64'(heard_ena), 64'd1);
        chk("mid second emission seq", 64'(heard_seq), 64'd1);
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        chk("mid rst say_rdy",   64'(say_rdy),   64'd0);
        chk("mid rst heard_ena", 64'(heard_ena), 64'd0);
        chk("mid rst heard_v",   64'(heard_v),   64'd0);
        chk("mid rst heard_seq", 64'(heard_seq), 64'd0);
        chk("mid rst occupancy", 64'(occ),       64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk("mid release occupancy", 64'(occ),       64'd0);
        chk("mid release say_rdy",   64'(say_rdy),   64'd1);
        chk("mid release heard_ena", 64'(heard_ena), 64'd0);
        say_ena = 1'b1; say_v = 32'h9; say_rep = 4'd0;
        @(negedge CLK);
        say_ena = 1'b0;
        #1;
        chk("after rst heard_ena", 64'(heard_ena), 64'd1);
        chk("after rst heard_v",   64'(heard_v),   64'h9);
        chk("after rst heard_seq", 64'(heard_seq), 64'd0);
        @(negedge CLK);
        #1;
        chk("after rst drained", 64'(occ), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
